// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo PWM controller: period and
// select-width helpers, saturating arithmetic and the default pulse widths.
package servo_pkg;

   // Default high times in clocks for a 50 MHz clock: 0, 90 and 180 degrees
   localparam int DEF_MIN_PW    = 25_000;
   localparam int DEF_CENTER_PW = 75_000;
   localparam int DEF_MAX_PW    = 125_000;

   // Command decoded from the one-shot inputs, routed to the selected channel
   typedef enum logic [1:0] {
      CMD_NONE   = 2'd0,
      CMD_INC    = 2'd1,
      CMD_DEC    = 2'd2,
      CMD_CENTER = 2'd3
   } cmd_e;

   // Frame length in clocks; a zero frame rate yields 0 so the range checks trip
   function automatic int calcPeriod(input int clkFreq, input int pwmFreq);
      return (pwmFreq > 0) ? (clkFreq / pwmFreq) : 0;
   endfunction

   // Width of the channel select register, never narrower than one bit
   function automatic int chWidth(input int numCh);
      return (numCh <= 1) ? 1 : $clog2(numCh);
   endfunction

   // value + step clamped to limit, computed one bit wider so it cannot wrap
   function automatic logic [63:0] satAdd(input logic [63:0] value,
                                          input logic [63:0] step,
                                          input logic [63:0] limit);
      logic [64:0] sum;
      sum = {1'b0, value} + {1'b0, step};
      if (sum > {1'b0, limit}) begin
         return limit;
      end
      return sum[63:0];
   endfunction

   // value - step clamped to limit; the floor test is done one bit wider
   function automatic logic [63:0] satSub(input logic [63:0] value,
                                          input logic [63:0] step,
                                          input logic [63:0] limit);
      logic [64:0] floorVal;
      floorVal = {1'b0, limit} + {1'b0, step};
      if ({1'b0, value} < floorVal) begin
         return limit;
      end
      return value - step;
   endfunction

endpackage

// File: rtl/servo_pwm_multi_channel.sv
// One servo channel: target and slew-limited current pulse width, plus the
// registered compare against the shared period counter.
module servo_channel
   import servo_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int MIN_PW    = DEF_MIN_PW,
   parameter int MAX_PW    = DEF_MAX_PW,
   parameter int CENTER_PW = DEF_CENTER_PW,
   parameter int STEP      = 10_000,
   parameter int SLEW      = 2_500
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             frameEnd_i,
   input  cmd_e             cmd_i,
   output logic             pwm_o,
   output logic [CNT_W-1:0] target_o
);

   localparam logic [CNT_W-1:0] CENTER_C = CNT_W'(CENTER_PW);
   localparam logic [CNT_W-1:0] SLEW_C   = CNT_W'(SLEW);

   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] current_q, current_d;
   logic             pwm_q;

   // Apply the routed command to the target with saturation at MIN/MAX
   always_comb begin
      target_d = target_q;
      case (cmd_i)
         CMD_CENTER: target_d = CENTER_C;
         CMD_INC:    target_d = CNT_W'(satAdd(64'(target_q), 64'(STEP), 64'(MAX_PW)));
         CMD_DEC:    target_d = CNT_W'(satSub(64'(target_q), 64'(STEP), 64'(MIN_PW)));
         default:    target_d = target_q;
      endcase
   end

   // Move current toward target by at most SLEW, only at the frame boundary,
   // using the target as it stood before this edge
   always_comb begin
      current_d = current_q;
      if (frameEnd_i) begin
         if (target_q >= current_q) begin
            if ((SLEW == 0) || ((target_q - current_q) <= SLEW_C)) begin
               current_d = target_q;
            end else begin
               current_d = current_q + SLEW_C;
            end
         end else begin
            if ((SLEW == 0) || ((current_q - target_q) <= SLEW_C)) begin
               current_d = target_q;
            end else begin
               current_d = current_q - SLEW_C;
            end
         end
      end
   end

   // Width registers and the registered PWM compare
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         target_q  <= CENTER_C;
         current_q <= CENTER_C;
         pwm_q     <= 1'b0;
      end else begin
         target_q  <= target_d;
         current_q <= current_d;
         pwm_q     <= (cnt_i < current_q);
      end
   end

   assign pwm_o    = pwm_q;
   assign target_o = target_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM controller: shared period counter, channel select
// and command decode feeding NUM_CH servo_channel instances.
module servo_pwm_multi
   import servo_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int PWM_FREQ  = 50,
   parameter int NUM_CH    = 4,
   parameter int MIN_PW    = DEF_MIN_PW,
   parameter int MAX_PW    = DEF_MAX_PW,
   parameter int CENTER_PW = DEF_CENTER_PW,
   parameter int STEP      = 10_000,
   parameter int SLEW      = 2_500,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_pulse,
   input  logic              dec_pulse,
   input  logic              center_pulse,
   input  logic              sel_pulse,
   output logic [NUM_CH-1:0] pwm_out,
   output logic [NUM_CH-1:0] sel_onehot,
   output logic              at_min,
   output logic              at_max,
   output logic              frame_start
);

   localparam int PERIOD = calcPeriod(CLK_FREQ, PWM_FREQ);
   localparam int CH_W   = chWidth(NUM_CH);

   // Reject parameter sets that cannot produce a valid servo frame
   if (!((MIN_PW <= CENTER_PW) && (CENTER_PW <= MAX_PW) && (MAX_PW < PERIOD))) begin : gen_errPw
      $error("servo_pwm_multi: need MIN_PW <= CENTER_PW <= MAX_PW < PERIOD");
   end
   if (STEP <= 0) begin : gen_errStep
      $error("servo_pwm_multi: STEP must be positive");
   end
   if ((NUM_CH < 1) || (NUM_CH > 16)) begin : gen_errCh
      $error("servo_pwm_multi: NUM_CH must be 1..16");
   end
   if ((CNT_W < 2) || (CNT_W > 64) || ((64'(PERIOD - 1) >> CNT_W) != 64'd0)) begin : gen_errW
      $error("servo_pwm_multi: CNT_W must be 2..64 and hold PERIOD-1");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CH_W-1:0]  sel_q, sel_d;
   logic             frameStart_q;
   logic             frameEnd;
   cmd_e             cmd;
   logic [CNT_W-1:0] targetArr [NUM_CH];

   assign frameEnd = (cnt_q == CNT_W'(PERIOD - 1));

   // Next counter value and next select, wrapping at their limits
   always_comb begin
      cnt_d = frameEnd ? '0 : cnt_q + CNT_W'(1);
      sel_d = sel_q;
      if (sel_pulse) begin
         sel_d = (sel_q == CH_W'(NUM_CH - 1)) ? '0 : sel_q + CH_W'(1);
      end
   end

   // Shared counter, select and frame-start flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q        <= '0;
         sel_q        <= '0;
         frameStart_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         sel_q        <= sel_d;
         frameStart_q <= frameEnd;
      end
   end

   // Command decode: center beats inc/dec, inc together with dec does nothing
   always_comb begin
      cmd = CMD_NONE;
      if (center_pulse) begin
         cmd = CMD_CENTER;
      end else if (inc_pulse && !dec_pulse) begin
         cmd = CMD_INC;
      end else if (dec_pulse && !inc_pulse) begin
         cmd = CMD_DEC;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
      cmd_e chCmd;
      assign chCmd = (sel_q == CH_W'(i)) ? cmd : CMD_NONE;

      servo_channel #(
         .CNT_W     (CNT_W),
         .MIN_PW    (MIN_PW),
         .MAX_PW    (MAX_PW),
         .CENTER_PW (CENTER_PW),
         .STEP      (STEP),
         .SLEW      (SLEW)
      ) u_channel (
         .clk_i      (clk),
         .rst_ni     (rst),
         .cnt_i      (cnt_q),
         .frameEnd_i (frameEnd),
         .cmd_i      (chCmd),
         .pwm_o      (pwm_out[i]),
         .target_o   (targetArr[i])
      );
   end

   // Status for the selected channel, decoded straight from registered state
   always_comb begin
      sel_onehot        = '0;
      sel_onehot[sel_q] = 1'b1;
      at_min            = (targetArr[sel_q] == CNT_W'(MIN_PW));
      at_max            = (targetArr[sel_q] == CNT_W'(MAX_PW));
   end

   assign frame_start = frameStart_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi with a 100-cycle frame, two channels,
// MIN/CENTER/MAX = 10/20/30, STEP 5 and SLEW 2.
module tb_servo_pwm_multi;

   localparam int PERIOD = 100;
   localparam int GUARD  = 5000;

   logic       clk = 1'b0;
   logic       rst;
   logic       inc_pulse, dec_pulse, center_pulse, sel_pulse;
   logic [1:0] pwm_out, sel_onehot;
   logic       at_min, at_max, frame_start;

   int errors = 0;
   int checks = 0;
   int tbCnt = 0;
   int frameNo = 0;
   int hi0 = 0;
   int hi1 = 0;

   typedef struct {
      int frame;
      int w0;
      int w1;
   } frameExp_t;

   typedef struct {
      int         frame;
      int         atCnt;
      bit         inc;
      bit         dec;
      bit         center;
      bit         sel;
      bit         expAtMin;
      bit         expAtMax;
      logic [1:0] expOnehot;
   } cmdVec_t;

   frameExp_t expQ[$];
   cmdVec_t   vecs[17];
   int        expW0[25];
   int        expW1[25];

   servo_pwm_multi #(
      .CLK_FREQ  (1000),
      .PWM_FREQ  (10),
      .NUM_CH    (2),
      .MIN_PW    (10),
      .MAX_PW    (30),
      .CENTER_PW (20),
      .STEP      (5),
      .SLEW      (2),
      .CNT_W     (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .inc_pulse    (inc_pulse),
      .dec_pulse    (dec_pulse),
      .center_pulse (center_pulse),
      .sel_pulse    (sel_pulse),
      .pwm_out      (pwm_out),
      .sel_onehot   (sel_onehot),
      .at_min       (at_min),
      .at_max       (at_max),
      .frame_start  (frame_start)
   );

   always #5 clk = ~clk;

   // One comparison: count it, and report it when the values differ
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference position in the frame, kept from the clock and reset alone
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         tbCnt <= 0;
      end else if (tbCnt == PERIOD - 1) begin
         tbCnt   <= 0;
         frameNo <= frameNo + 1;
      end else begin
         tbCnt <= tbCnt + 1;
      end
   end

   // Measure each channel's high time per frame and score it against the
   // expectation queued for that frame; also watch the frame_start pulse
   always @(negedge clk) begin : monitor
      frameExp_t e;
      if (!rst) begin
         hi0 = 0;
         hi1 = 0;
      end else begin
         if (pwm_out[0] === 1'b1) hi0++;
         if (pwm_out[1] === 1'b1) hi1++;
         if (tbCnt <= 1) begin
            checkOutput($sformatf("frame%0d frame_start@cnt%0d", frameNo, tbCnt),
                        32'(frame_start), 32'(tbCnt == 0));
         end
         if (tbCnt == PERIOD - 1) begin
            while (expQ.size() > 0 && expQ[0].frame < frameNo) begin
               e = expQ.pop_front();
               checks++;
               errors++;
               $display("[TB] FAIL frame%0d width: not measured, expected %0d/%0d",
                        e.frame, e.w0, e.w1);
            end
            if (expQ.size() > 0 && expQ[0].frame == frameNo) begin
               e = expQ.pop_front();
               checkOutput($sformatf("frame%0d ch0 width", frameNo), 32'(hi0), 32'(e.w0));
               checkOutput($sformatf("frame%0d ch1 width", frameNo), 32'(hi1), 32'(e.w1));
            end
            hi0 = 0;
            hi1 = 0;
         end
      end
   end

   // Advance to the negedge where the reference sits at the given frame/count
   task automatic waitAt(input int frame, input int cnt);
      int  guard;
      bit  found;
      guard = 0;
      found = 0;
      while (!found && guard < GUARD) begin
         @(negedge clk);
         guard++;
         found = (frameNo == frame) && (tbCnt == cnt);
      end
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait frame%0d cnt%0d: timed out at frame%0d cnt%0d, required reach",
                  frame, cnt, frameNo, tbCnt);
      end
   endtask

   // Drive one command vector for a single cycle and check the status outputs
   task automatic applyStimulus(input int idx, input cmdVec_t v);
      waitAt(v.frame, v.atCnt);
      inc_pulse    = v.inc;
      dec_pulse    = v.dec;
      center_pulse = v.center;
      sel_pulse    = v.sel;
      @(negedge clk);
      inc_pulse    = 1'b0;
      dec_pulse    = 1'b0;
      center_pulse = 1'b0;
      sel_pulse    = 1'b0;
      checkOutput($sformatf("vec%0d at_min", idx), 32'(at_min), 32'(v.expAtMin));
      checkOutput($sformatf("vec%0d at_max", idx), 32'(at_max), 32'(v.expAtMax));
      checkOutput($sformatf("vec%0d sel_onehot", idx), 32'(sel_onehot), 32'(v.expOnehot));
   endtask

   // Main sequence: reset, table of commands, mid-frame reset, summary
   initial begin
      rst          = 1'b1;
      inc_pulse    = 1'b0;
      dec_pulse    = 1'b0;
      center_pulse = 1'b0;
      sel_pulse    = 1'b0;

      // Expected high time per frame, ch0 and ch1
      expW0 = '{20, 20, 20, 22, 24, 25, 25, 27, 29, 30, 30, 28, 26, 25, 25,
                25, 25, 25, 25, 25, 25, 25, 25, 23, 21};
      expW1 = '{20, 20, 20, 20, 20, 20, 20, 20, 20, 20, 20, 20, 20, 20, 20,
                20, 20, 20, 20, 22, 24, 25, 25, 25, 25};

      // frame, cnt, inc, dec, center, sel, at_min, at_max, sel_onehot after
      vecs = '{
         '{ 2, 50, 1, 0, 0, 0, 0, 0, 2'b01},   // ch0 target 20 -> 25
         '{ 6, 10, 1, 0, 0, 0, 0, 1, 2'b01},   // 25 -> 30
         '{ 6, 12, 1, 0, 0, 0, 0, 1, 2'b01},
         '{ 6, 14, 1, 0, 0, 0, 0, 1, 2'b01},
         '{ 6, 16, 1, 0, 0, 0, 0, 1, 2'b01},
         '{ 6, 18, 1, 0, 0, 0, 0, 1, 2'b01},
         '{ 6, 20, 1, 0, 0, 0, 0, 1, 2'b01},   // sixth inc, still 30
         '{10, 30, 0, 1, 0, 1, 0, 0, 2'b10},   // dec hits ch0, select moves to ch1
         '{14, 10, 0, 1, 0, 0, 0, 0, 2'b10},   // ch1 20 -> 15
         '{14, 20, 1, 0, 1, 0, 0, 0, 2'b10},   // center wins: ch1 -> 20
         '{16, 10, 1, 1, 0, 0, 0, 0, 2'b10},   // inc+dec ignored
         '{17, 99, 1, 0, 0, 0, 0, 0, 2'b10},   // ch1 -> 25 on the boundary cycle
         '{22, 10, 0, 0, 0, 1, 0, 0, 2'b01},   // select wraps back to ch0
         '{22, 20, 0, 1, 0, 0, 0, 0, 2'b01},   // 25 -> 20
         '{22, 22, 0, 1, 0, 0, 0, 0, 2'b01},   // 20 -> 15
         '{22, 24, 0, 1, 0, 0, 1, 0, 2'b01},   // 15 -> 10
         '{22, 26, 0, 1, 0, 0, 1, 0, 2'b01}    // stays at 10
      };

      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset pwm_out", 32'(pwm_out), 32'd0);
      checkOutput("reset frame_start", 32'(frame_start), 32'd0);
      checkOutput("reset sel_onehot", 32'(sel_onehot), 32'd1);
      checkOutput("reset at_min", 32'(at_min), 32'd0);
      checkOutput("reset at_max", 32'(at_max), 32'd0);

      for (int f = 0; f < 25; f++) begin
         expQ.push_back('{f, expW0[f], expW1[f]});
      end

      @(negedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 17; i++) begin
         applyStimulus(i, vecs[i]);
      end

      // Mid-frame reset while both outputs are high
      waitAt(25, 10);
      checkOutput("pre-reset pwm_out", 32'(pwm_out), 32'd3);
      checkOutput("pre-reset at_min", 32'(at_min), 32'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("mid-frame reset pwm_out", 32'(pwm_out), 32'd0);
      checkOutput("mid-frame reset frame_start", 32'(frame_start), 32'd0);
      checkOutput("mid-frame reset sel_onehot", 32'(sel_onehot), 32'd1);
      checkOutput("mid-frame reset at_min", 32'(at_min), 32'd0);
      checkOutput("mid-frame reset at_max", 32'(at_max), 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      expQ.push_back('{25, 20, 20});
      expQ.push_back('{26, 20, 20});

      waitAt(27, 1);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
